paddle_controller: RTL and testbench
====================================

// Module: paddle_controller
// PURPOSE
//  Frame-synchronous paddle engine for breakout: owns the paddle X position.
//  Moves the paddle from the left/right buttons with acceleration and clamps it to the screen.
//  Animates the paddle between a wide and a narrow width.
//  Produces a registered in_paddle pixel flag and the current extent for collision logic.
//  Sits between input debouncing and the pixel mux / ball collision block.
// PARAMETERS
//  SCREEN_W     640        visible width in pixels; x range 0..SCREEN_W-1
//  PADDLE_Y     456        top row of paddle
//  PADDLE_H     8          paddle height in rows
//  WIDE_W       99         wide-mode width; odd
//  NARROW_W     49         narrow-mode width; odd, < WIDE_W
//  SPEED_MAX    8          max pixels moved per frame
//  ACCEL        1          speed increment per frame while a button is held
//  PADDLE_COLOR 6'b111111  BBGGRR color constant
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  frame_tick in   1   1-cycle pulse once per frame (start of vblank)
//  btn_left   in   1   level; move left request
//  btn_right  in   1   level; move right request
//  narrow     in   1   level; 1 = target width NARROW_W, 0 = WIDE_W
//  hpos       in   10  current beam column
//  vpos       in   9   current beam row
//  x          out  10  paddle centre column (registered)
//  half_w     out  7   current (width-1)/2 (registered)
//  in_paddle  out  1   beam inside paddle, 1-cycle latency vs hpos/vpos
//  color      out  6   PADDLE_COLOR, constant
// BEHAVIOUR
//  Reset: x=SCREEN_W/2 (320), width=WIDE_W (half_w=49), speed=0, dir=NONE, in_paddle=0.
//  State (dir): NONE / LEFT / RIGHT. It is sampled and updated only on frame_tick.
//  Nothing moves between ticks.
//  Button decode: left&~right -> LEFT; right&~left -> RIGHT; both or neither -> NONE.
//  Speed on tick:
//   - Same dir as last tick: speed = min(speed+ACCEL, SPEED_MAX).
//   - New non-NONE dir: speed = ACCEL.
//   - NONE: speed = 0.
//  The position uses the speed value computed in that same tick.
//  Width animation on tick: if width != target, width steps by 2 toward target.
//   - Width stays odd.
//   - Width never overshoots the target.
//  half_w = (width-1)/2.
//  A narrow toggle mid-animation simply retargets; no restart.
//  Position on tick:
//   - nx = x -/+ speed. Compute in 12-bit signed so nothing wraps below 0 or above 1023.
//   - Then clamp to [hw, SCREEN_W-1-hw], using the new half-width hw.
//   - Widening at a wall therefore pushes x inward in the same tick.
//  Extent: paddle covers columns x-half_w .. x+half_w inclusive.
//  Extent: paddle covers rows PADDLE_Y .. PADDLE_Y+PADDLE_H-1.
//  in_paddle is registered from the comparison of hpos/vpos against the extent.
//   - It uses the x/half_w values present in the same cycle.
//   - Latency is exactly 1 clk.
//  frame_tick asserted together with reset: reset wins.
//  Reset mid-animation or mid-move returns all state to reset values on the next edge.
// STRUCTURE
//  Shared package breakout_pkg:
//   - SCREEN_W, PADDLE_Y, PADDLE_H, color localparams.
//   - dir_t enum {DIR_NONE, DIR_LEFT, DIR_RIGHT}.
//  One sub-module, paddle_raster: registered extent comparator (hpos, vpos, x, half_w -> in_paddle).
//  Motion, width animation and clamp stay in paddle_controller.
// TESTING
//  1. Reset released, no buttons, 10 ticks -> x=320, half_w=49, speed 0.
//     Pixel (320,456) gives in_paddle=1 one clk later; (370,456) gives 0.
//  2. Hold btn_right 10 ticks (ACCEL=1, MAX=8) -> x deltas 1,2,...,8,8,8; x=320+52=372.
//  3. Hold btn_left from x=60 -> x clamps at 49 and never below; speed keeps saturating.
//     Both buttons held -> x frozen, speed 0.
//  4. narrow=1 at x=320 -> half_w goes 49,48,...,24 over 25 ticks, then holds.
//     Toggling back midway reverses with no jump.
//  5. narrow 1->0 with x=24 at the left wall -> each tick x follows half_w (25,26,...,49).
//     The left edge stays at column 0.
//  6. reset pulse mid-move (speed=5) -> next clk x=320, speed 0, in_paddle 0, half_w=49.

Source files
------------

// File: rtl/breakout_pkg.sv
// Shared constants and types for the breakout game datapath.
//   SCREEN_W, PADDLE_Y, PADDLE_H : playfield geometry
//   PADDLE_COLOR                 : BBGGRR paddle colour
//   dir_t                        : paddle motion direction
package breakout_pkg;

  localparam int SCREEN_W = 640;
  localparam int PADDLE_Y = 456;
  localparam int PADDLE_H = 8;

  localparam logic [5:0] PADDLE_COLOR = 6'b111111;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

endpackage

// File: rtl/paddle_raster.sv
// Registered paddle extent comparator.
//   clk, reset : clock, synchronous active-high reset
//   hpos, vpos : current beam position
//   x, half_w  : paddle centre column and half-width (same-cycle values)
//   in_paddle  : beam inside the paddle rectangle, one clock later
module paddle_raster
  import breakout_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [8:0] vpos,
  input  logic [9:0] x,
  input  logic [6:0] half_w,
  output logic       in_paddle
);

  localparam logic [8:0] ROW_TOP = 9'(PADDLE_Y);
  localparam logic [8:0] ROW_BOT = 9'(PADDLE_Y + PADDLE_H - 1);

  logic signed [10:0] col_lo;
  logic signed [10:0] col_hi;
  logic signed [10:0] col;
  logic               hit_p0;

  // Signed extent so a left edge below column 0 could never wrap around.
  always_comb begin
    col    = signed'({1'b0, hpos});
    col_lo = signed'({1'b0, x}) - signed'({4'b0000, half_w});
    col_hi = signed'({1'b0, x}) + signed'({4'b0000, half_w});
    hit_p0 = (col >= col_lo) && (col <= col_hi) &&
             (vpos >= ROW_TOP) && (vpos <= ROW_BOT);
  end

  // Stage p0 -> output register
  always_ff @(posedge clk) begin
    if (reset) in_paddle <= 1'b0;
    else       in_paddle <= hit_p0;
  end

endmodule

// File: rtl/paddle_controller.sv
// Frame-synchronous breakout paddle engine: accelerating motion from the
// buttons, wide/narrow width animation, wall clamp and pixel hit flag.
//   clk, reset           : clock, synchronous active-high reset
//   frame_tick           : one-cycle pulse per frame; all state moves only here
//   btn_left, btn_right  : move requests (levels)
//   narrow               : 1 = narrow target width, 0 = wide
//   hpos, vpos           : beam position
//   x, half_w            : paddle centre and (width-1)/2, registered
//   in_paddle            : beam inside paddle, 1 clk latency
//   color                : constant paddle colour
module paddle_controller
  import breakout_pkg::*;
#(
  parameter int WIDE_W    = 99,
  parameter int NARROW_W  = 49,
  parameter int SPEED_MAX = 8,
  parameter int ACCEL     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       narrow,
  input  logic [9:0] hpos,
  input  logic [8:0] vpos,
  output logic [9:0] x,
  output logic [6:0] half_w,
  output logic       in_paddle,
  output logic [5:0] color
);

  localparam logic [9:0]         X_RESET     = 10'(SCREEN_W / 2);
  localparam logic [6:0]         HALF_WIDE   = 7'((WIDE_W - 1) / 2);
  localparam logic [6:0]         HALF_NARROW = 7'((NARROW_W - 1) / 2);
  localparam logic [4:0]         SPD_MAX     = 5'(SPEED_MAX);
  localparam logic [5:0]         SPD_ACC     = 6'(ACCEL);
  localparam logic signed [11:0] X_LAST      = 12'(SCREEN_W - 1);

  dir_t               dir, dir_next, req;
  logic [4:0]         speed, speed_next, step_speed;
  logic [5:0]         speed_sum;
  logic [6:0]         half_next, step_half, target_half;
  logic [9:0]         x_next;
  logic signed [11:0] nx, lim_lo, lim_hi, nx_clamped;

  assign color = PADDLE_COLOR;

  // Width is always odd, so stepping the width by 2 is stepping half_w by 1;
  // a single step can never overshoot the target.
  always_comb begin
    req = DIR_NONE;
    if (btn_left && !btn_right)      req = DIR_LEFT;
    else if (btn_right && !btn_left) req = DIR_RIGHT;

    speed_sum  = {1'b0, speed} + SPD_ACC;
    step_speed = '0;
    if (req == DIR_NONE)   step_speed = '0;
    else if (req == dir)   step_speed = (speed_sum > {1'b0, SPD_MAX}) ? SPD_MAX : speed_sum[4:0];
    else                   step_speed = SPD_ACC[4:0];

    target_half = narrow ? HALF_NARROW : HALF_WIDE;
    step_half   = half_w;
    if (half_w < target_half)      step_half = half_w + 7'd1;
    else if (half_w > target_half) step_half = half_w - 7'd1;

    // 12-bit signed motion so overshoot past either wall never wraps; the
    // clamp uses the new half-width, so widening at a wall pushes x inward.
    nx = signed'({2'b00, x});
    if (req == DIR_LEFT)       nx = nx - signed'({7'b0000000, step_speed});
    else if (req == DIR_RIGHT) nx = nx + signed'({7'b0000000, step_speed});
    lim_lo = signed'({5'b00000, step_half});
    lim_hi = X_LAST - lim_lo;
    nx_clamped = nx;
    if (nx < lim_lo)      nx_clamped = lim_lo;
    else if (nx > lim_hi) nx_clamped = lim_hi;

    dir_next   = dir;
    speed_next = speed;
    half_next  = half_w;
    x_next     = x;
    if (frame_tick) begin
      dir_next   = req;
      speed_next = step_speed;
      half_next  = step_half;
      x_next     = 10'(nx_clamped);
    end
  end

  // Frame state register
  always_ff @(posedge clk) begin
    if (reset) begin
      dir    <= DIR_NONE;
      speed  <= '0;
      half_w <= HALF_WIDE;
      x      <= X_RESET;
    end else begin
      dir    <= dir_next;
      speed  <= speed_next;
      half_w <= half_next;
      x      <= x_next;
    end
  end

  paddle_raster u_raster (
    .clk       (clk),
    .reset     (reset),
    .hpos      (hpos),
    .vpos      (vpos),
    .x         (x),
    .half_w    (half_w),
    .in_paddle (in_paddle)
  );

endmodule

// File: tb/tb_paddle_controller.sv
// Self-checking bench for paddle_controller: directed scenarios followed by
// random button/width/pixel traffic, all checked against a frame-level model.
module tb_paddle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       narrow = 1'b0;
  logic [9:0] hpos = '0;
  logic [8:0] vpos = '0;
  logic [9:0] x;
  logic [6:0] half_w;
  logic       in_paddle;
  logic [5:0] color;

  int total = 0;
  int bad   = 0;

  // Model: paddle as centre, full width (odd), speed and last direction (-1/0/+1).
  int mx, mw, msp, mdir;

  paddle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .narrow     (narrow),
    .hpos       (hpos),
    .vpos       (vpos),
    .x          (x),
    .half_w     (half_w),
    .in_paddle  (in_paddle),
    .color      (color)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int mhw();
    return (mw - 1) / 2;
  endfunction

  task automatic model_reset();
    mx = 320; mw = 99; msp = 0; mdir = 0;
  endtask

  task automatic model_tick(input logic l, input logic r, input logic n);
    int d, tgt, nx, hw;
    d = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
    if (d == 0)         msp = 0;
    else if (d == mdir) msp = (msp + 1 > 8) ? 8 : msp + 1;
    else                msp = 1;
    mdir = d;
    tgt = n ? 49 : 99;
    if (mw < tgt)      mw = (mw + 2 > tgt) ? tgt : mw + 2;
    else if (mw > tgt) mw = (mw - 2 < tgt) ? tgt : mw - 2;
    hw = mhw();
    nx = mx + d * msp;
    if (nx < hw) nx = hw;
    if (nx > 639 - hw) nx = 639 - hw;
    mx = nx;
  endtask

  task automatic tick(input logic l, input logic r, input logic n, input string tag);
    @(negedge clk);
    btn_left = l; btn_right = r; narrow = n; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_tick(l, r, n);
    chk({tag, ".x"}, x, mx);
    chk({tag, ".half_w"}, half_w, mhw());
  endtask

  task automatic pix(input int h, input int v, input string tag);
    int e;
    @(negedge clk);
    hpos = 10'(h); vpos = 9'(v);
    e = (h >= mx - mhw() && h <= mx + mhw() && v >= 456 && v <= 463) ? 1 : 0;
    @(negedge clk);
    chk(tag, in_paddle, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; btn_left = 0; btn_right = 0; narrow = 0; frame_tick = 0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    // 1: reset values and idle frames
    repeat (3) @(negedge clk);
    chk("rst.x", x, 320);
    chk("rst.half_w", half_w, 49);
    chk("rst.in_paddle", in_paddle, 0);
    chk("color", color, 63);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick(0, 0, 0, "idle");
    chk("idle.x_final", x, 320);
    pix(320, 456, "pix.centre");
    pix(370, 456, "pix.right_out");
    pix(369, 456, "pix.right_edge");
    pix(271, 463, "pix.left_edge_bottom");
    pix(270, 456, "pix.left_out");
    pix(320, 455, "pix.above");
    pix(320, 464, "pix.below");

    // 2: accelerate right
    for (int i = 0; i < 10; i++) tick(0, 1, 0, "right");
    chk("right.x_final", x, 372);

    // 3: from 320, 36 left frames reach 60, then clamp at 49
    do_reset();
    for (int i = 0; i < 36; i++) tick(1, 0, 0, "left");
    chk("left.x60", x, 60);
    for (int i = 0; i < 6; i++) tick(1, 0, 0, "left_wall");
    chk("left.clamp", x, 49);
    for (int i = 0; i < 3; i++) tick(1, 1, 0, "both");
    chk("both.frozen", x, 49);
    tick(0, 1, 0, "restart");
    chk("restart.speed1", x, 50);

    // 4: narrow animation, then reversal midway
    do_reset();
    for (int i = 0; i < 25; i++) tick(0, 0, 1, "narrow");
    chk("narrow.half_final", half_w, 24);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, "narrow_hold");
    do_reset();
    for (int i = 0; i < 10; i++) tick(0, 0, 1, "narrow_mid");
    chk("narrow_mid.half", half_w, 39);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, "widen_back");
    chk("widen_back.half", half_w, 43);

    // 5: widen while pinned at the left wall
    do_reset();
    for (int i = 0; i < 25; i++) tick(0, 0, 1, "nw");
    for (int i = 0; i < 45; i++) tick(1, 0, 1, "nw_left");
    chk("nw.x_wall", x, 24);
    for (int i = 0; i < 25; i++) begin
      tick(0, 0, 0, "wall_widen");
      chk("wall_widen.left_edge", 32'(x) - 32'(half_w), 0);
    end
    chk("wall_widen.x_final", x, 49);
    pix(0, 460, "pix.col0");

    // 6: reset mid-move, asserted together with frame_tick
    do_reset();
    for (int i = 0; i < 5; i++) tick(0, 1, 1, "premove");
    pix(mx, 458, "pix.before_reset");
    @(negedge clk);
    reset = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    reset = 1'b0; frame_tick = 1'b0;
    model_reset();
    chk("midrst.x", x, 320);
    chk("midrst.half_w", half_w, 49);
    chk("midrst.in_paddle", in_paddle, 0);
    tick(0, 1, 0, "post_rst");
    chk("post_rst.speed1", x, 321);

    // random traffic
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic l, r, n;
      int b;
      b = int'($urandom_range(0, 9));
      l = (b < 4) || (b == 8);
      r = (b >= 4 && b < 8) || (b == 8);
      n = ($urandom_range(0, 3) == 0) ? ~narrow : narrow;
      tick(l, r, n, "rand");
      if ((i % 4) == 0)
        pix(mx + int'($urandom_range(0, 120)) - 60, int'($urandom_range(450, 470)), "rand.pix");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
